bitwise_piso_tx: RTL

Parallel-in/serial-out transmitter. It is the sending end of the team's serial-in shift-register receiver, which shifts `d` into the LSB when `en` is high. The block accepts a p_nbits word over a valid/ready handshake and emits it MSB-first as a (`q`, `q_en`) bit stream. A receiver wired as `d=q`, `en=q_en` and built with the same p_nbits holds the original word after the last strobe.

---
 rtl/bitwise_pkg.sv | 14 +
 rtl/bitwise_bit_counter.sv | 31 +++
 rtl/bitwise_piso_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/bitwise_pkg.sv
// Shared types and sizing helpers for the bitwise serial transmitter/receiver pair.
package bitwise_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bitwise_tx_state_t;

    // Bit-counter width for an n-bit frame; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bitwise_bit_counter.sv
// Frame bit counter: clear has priority over increment; tc flags the last bit position.
module bitwise_bit_counter
    import bitwise_pkg::*;
#(
    parameter int p_nbits = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int                 p_width = cnt_width(p_nbits);
    localparam logic [p_width-1:0] p_last  = p_width'(p_nbits - 1);

    logic [p_width-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + p_width'(1);
        end
    end

    assign tc = (count == p_last);

endmodule

// File: rtl/bitwise_piso_tx.sv
// MSB-first parallel-in/serial-out transmitter with valid/ready input and pause.
// Handshake: a word transfers at a posedge where in_valid & in_ready are both high.
module bitwise_piso_tx
    import bitwise_pkg::*;
#(
    parameter int   p_nbits      = 8,
    parameter logic p_idle_value = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [p_nbits-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               pause,
    output logic               q,
    output logic               q_en,
    output logic               busy,
    output logic               done
);

    bitwise_tx_state_t  state;
    bitwise_tx_state_t  next_state;
    logic [p_nbits-1:0] shift_reg;
    logic               tc;
    logic               last;
    logic               accept;

    assign accept = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    next_state = accept ? SHIFT : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        q_en     = 1'b0;
        busy     = 1'b0;
        last     = 1'b0;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                busy     = 1'b1;
                q_en     = ~pause;
                last     = ~pause & tc;
                in_ready = last;
                done     = last;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Idle fill bits shifted in behind the frame leave the register all idle once
    // the last bit goes out, so the MSB alone gives the correct idle level on q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_reg <= {p_nbits{p_idle_value}};
        end else if (accept) begin
            shift_reg <= in_data;
        end else if (q_en) begin
            shift_reg <= {shift_reg[p_nbits-2:0], p_idle_value};
        end
    end

    assign q = shift_reg[p_nbits-1];

    // Clearing on the last strobe keeps the counter from running past p_nbits-1.
    bitwise_bit_counter #(
        .p_nbits(p_nbits)
    ) u_bit_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (accept | last),
        .inc    (q_en),
        .tc     (tc)
    );

endmodule
